// File: rtl/dac_pkg.sv
// dac_pkg: shared state encoding, word geometry and default DAC command bytes
package dac_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD    = 3'd1;
  localparam state_t SHIFT_A = 3'd2;
  localparam state_t GAP     = 3'd3;
  localparam state_t SHIFT_B = 3'd4;
  localparam state_t DONE    = 3'd5;
  localparam int WORD_BITS   = 24;
  localparam int SAMPLE_BITS = 16;
  localparam logic [7:0] CMD_A_DEFAULT = 8'h30;
  localparam logic [7:0] CMD_B_DEFAULT = 8'h31;
endpackage

// File: rtl/dac_saturate.sv
// dac_saturate: scales a 32-bit accumulator total, clamps to 16 bits and converts to offset binary
module dac_saturate import dac_pkg::*; #(
  parameter int SHIFT = 5
) (
  input  logic [31:0]            sample,
  output logic [SAMPLE_BITS-1:0] data,
  output logic                   clip
);
  logic signed [31:0] scaled;
  logic [SAMPLE_BITS-1:0] clamped;
  logic hi, lo;
  // Arithmetic shift keeps the sign; clamp to the signed 16-bit range, then flip the MSB for offset binary
  always_comb begin
    scaled  = $signed(sample) >>> SHIFT;
    hi      = scaled > 32'sd32767;
    lo      = scaled < -32'sd32768;
    clamped = hi ? 16'h7fff : lo ? 16'h8000 : scaled[SAMPLE_BITS-1:0];
    data    = {~clamped[SAMPLE_BITS-1], clamped[SAMPLE_BITS-2:0]};
    clip    = hi || lo;
  end
endmodule

// File: rtl/dac_frame_serialiser.sv
// dac_frame_serialiser: saturates both harmonic totals and shifts two command+data words to a dual-channel SPI DAC
module dac_frame_serialiser import dac_pkg::*; #(
  parameter int         SHIFT      = 5,
  parameter int         CLK_DIV    = 4,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] CMD_A      = CMD_A_DEFAULT,
  parameter logic [7:0] CMD_B      = CMD_B_DEFAULT
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Start,
  input  logic [31:0] i_Sample_L,
  input  logic [31:0] i_Sample_R,
  output logic        o_SPI_CS,
  output logic        o_SPI_Clock,
  output logic        o_SPI_Data,
  output logic        o_Busy,
  output logic        o_Clip,
  output logic        o_Overrun
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state, state_next;
  logic [31:0] sample_l, sample_r;
  logic [WORD_BITS-1:0] word_a, word_b, cur_word;
  logic [SAMPLE_BITS-1:0] data_l, data_r;
  logic clip_l, clip_r;
  logic [4:0] bit_idx;
  logic [DW-1:0] div;
  logic [GW-1:0] gap;
  logic shifting, bit_end, word_end, gap_end;
  dac_saturate #(.SHIFT(SHIFT)) u_sat_l (.sample(sample_l), .data(data_l), .clip(clip_l));
  dac_saturate #(.SHIFT(SHIFT)) u_sat_r (.sample(sample_r), .data(data_r), .clip(clip_r));
  assign shifting = state == SHIFT_A || state == SHIFT_B;
  assign bit_end  = div == DW'(CLK_DIV - 1);
  assign word_end = bit_end && bit_idx == 5'd0;
  assign gap_end  = gap == GW'(GAP_CYCLES - 1);
  // State register
  always_ff @(posedge i_Clock)
    state <= !i_Reset_n ? IDLE : state_next;
  // Next-state sequencing through one frame
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = i_Start ? LOAD : IDLE;
      LOAD:    state_next = SHIFT_A;
      SHIFT_A: state_next = word_end ? GAP : SHIFT_A;
      GAP:     state_next = gap_end ? SHIFT_B : GAP;
      SHIFT_B: state_next = word_end ? DONE : SHIFT_B;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // Capture both totals only when a start is accepted, so inputs may move afterwards
  always_ff @(posedge i_Clock)
    if (i_Reset_n && state == IDLE && i_Start) begin
      sample_l <= i_Sample_L;
      sample_r <= i_Sample_R;
    end
  // Build both channel words once, in LOAD
  always_ff @(posedge i_Clock)
    if (state == LOAD) begin
      word_a <= {CMD_A, data_l};
      word_b <= {CMD_B, data_r};
    end
  // SCK divider and bit index: each bit spends CLK_DIV clocks, index steps when the divider wraps
  always_ff @(posedge i_Clock)
    if (!i_Reset_n || !shifting) begin
      div     <= '0;
      bit_idx <= 5'(WORD_BITS - 1);
    end else begin
      div     <= bit_end ? '0 : div + 1'b1;
      bit_idx <= bit_end ? bit_idx - 5'd1 : bit_idx;
    end
  // Counts the clocks CS stays high between the two words
  always_ff @(posedge i_Clock)
    gap <= (!i_Reset_n || state != GAP) ? '0 : gap + 1'b1;
  // SPI pins and status strobes decoded from state and counters
  always_comb begin
    cur_word    = state == SHIFT_B ? word_b : word_a;
    o_SPI_CS    = !shifting;
    o_SPI_Clock = shifting && div >= DW'(CLK_DIV / 2);
    o_SPI_Data  = shifting && cur_word[bit_idx];
    o_Busy      = state != IDLE;
    o_Clip      = state == LOAD && (clip_l || clip_r);
    o_Overrun   = i_Reset_n && i_Start && state != IDLE;
  end
endmodule

// File: tb/tb_dac_frame_serialiser.sv
// tb_dac_frame_serialiser: directed and randomized frames checked against an arithmetic model and an SPI monitor
module tb_dac_frame_serialiser;
  localparam int SHIFT = 5;
  localparam int CLK_DIV = 4;
  localparam int GAP_CYCLES = 4;
  localparam int FRAME_LEN = 2 + 2 * 24 * CLK_DIV + GAP_CYCLES + 1;
  logic clk = 1'b0;
  logic i_Reset_n = 1'b0;
  logic i_Start = 1'b0;
  logic [31:0] i_Sample_L = '0;
  logic [31:0] i_Sample_R = '0;
  logic o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Clip, o_Overrun;
  int checks = 0;
  int errors = 0;
  int fid = 0;
  logic [23:0] mon_q[$];
  int rises = 0;
  int gap_len = 0;
  int viol = 0;
  dac_frame_serialiser dut (
    .i_Clock(clk), .i_Reset_n(i_Reset_n), .i_Start(i_Start),
    .i_Sample_L(i_Sample_L), .i_Sample_R(i_Sample_R),
    .o_SPI_CS(o_SPI_CS), .o_SPI_Clock(o_SPI_Clock), .o_SPI_Data(o_SPI_Data),
    .o_Busy(o_Busy), .o_Clip(o_Clip), .o_Overrun(o_Overrun)
  );
  initial forever #5 clk = ~clk;
  // SPI monitor: shifts data on SCK rising edges while CS is low, and checks bus discipline
  initial begin
    int cyc, last_rise, nb;
    logic pcs, psck, pdata;
    logic [23:0] sh;
    cyc = 0; last_rise = 0; nb = 0; pcs = 1'b1; psck = 1'b0; pdata = 1'b0; sh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!o_SPI_CS && o_SPI_Clock && !psck) begin
        sh = {sh[22:0], o_SPI_Data};
        nb++;
        rises++;
      end
      if (o_SPI_CS && (o_SPI_Clock || o_SPI_Data)) viol++;
      if (o_SPI_Data !== pdata && !(psck && !o_SPI_Clock) && !(pcs && !o_SPI_CS) && !(!pcs && o_SPI_CS)) viol++;
      if (!pcs && o_SPI_CS) begin
        if (nb == 24) mon_q.push_back(sh);
        last_rise = cyc;
      end
      if (pcs && !o_SPI_CS) begin
        gap_len = cyc - last_rise;
        nb = 0;
      end
      pcs = o_SPI_CS; psck = o_SPI_Clock; pdata = o_SPI_Data;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Floor division by 2**SHIFT, clamp to signed 16 bits, bias by 32768
  function automatic logic [23:0] model_word(input logic [7:0] cmd, input logic [31:0] x, output bit clipped);
    longint v, d, q;
    v = longint'($signed(x));
    d = longint'(1) << SHIFT;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    clipped = q > 32767 || q < -32768;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return {cmd, 16'(q + 32768)};
  endfunction
  task automatic run_frame(input logic [31:0] l, input logic [31:0] r, input int ovr_at);
    logic [23:0] ea, eb, wa, wb;
    bit ca, cb;
    int n, clips, ovrs, nw;
    logic clip_first;
    ea = model_word(8'h30, l, ca);
    eb = model_word(8'h31, r, cb);
    mon_q.delete();
    rises = 0; n = 0; clips = 0; ovrs = 0; clip_first = 1'b0;
    fid++;
    @(negedge clk);
    i_Sample_L = l; i_Sample_R = r; i_Start = 1'b1;
    while (n < 400) begin
      @(negedge clk);
      n++;
      i_Start = (n == ovr_at);
      i_Sample_L = $urandom; i_Sample_R = $urandom;
      #1;
      if (n == 1) clip_first = o_Clip;
      clips += int'(o_Clip);
      ovrs += int'(o_Overrun);
      if (!o_Busy) break;
    end
    i_Start = 1'b0;
    nw = mon_q.size();
    wa = nw > 0 ? mon_q[0] : 'x;
    wb = nw > 1 ? mon_q[1] : 'x;
    check($sformatf("f%0d_len", fid), n, FRAME_LEN);
    check($sformatf("f%0d_nwords", fid), nw, 2);
    check($sformatf("f%0d_word_a", fid), 32'(wa), 32'(ea));
    check($sformatf("f%0d_word_b", fid), 32'(wb), 32'(eb));
    check($sformatf("f%0d_rises", fid), rises, 48);
    check($sformatf("f%0d_gap", fid), gap_len, GAP_CYCLES);
    check($sformatf("f%0d_clip_load", fid), 32'(clip_first), 32'(ca || cb));
    check($sformatf("f%0d_clip_count", fid), clips, (ca || cb) ? 1 : 0);
    check($sformatf("f%0d_overrun", fid), ovrs, ovr_at > 0 ? 1 : 0);
    check($sformatf("f%0d_bus_rules", fid), viol, 0);
  endtask
  initial begin
    logic [31:0] l, r;
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("reset_idle", 32'({o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Clip, o_Overrun}), 32'b100000);
    i_Reset_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check("idle_no_start", 32'({o_SPI_CS, o_SPI_Clock, o_SPI_Data, o_Busy, o_Clip, o_Overrun}), 32'b100000);
    check("idle_no_rises", rises, 0);
    run_frame(32'h0, 32'h0, 0);
    check("zero_word_a_const", 32'(model_word(8'h30, 32'h0, n[0])), 32'h308000);
    run_frame(32'h000FFFE0, 32'hFFF00000, 0);
    run_frame(32'h7FFFFFFF, 32'h80000000, 0);
    run_frame(32'h00100000, 32'h0, 0);
    run_frame($urandom, $urandom, 50);
    run_frame($urandom, $urandom, 198);
    run_frame($urandom, $urandom, 0);
    for (int i = 0; i < 6; i++) begin
      l = $urandom; r = $urandom;
      if (i % 2 == 0) begin
        l = $signed(l) >>> 10;
        r = $signed(r) >>> 11;
      end
      run_frame(l, r, 0);
    end
    mon_q.delete();
    @(negedge clk);
    i_Sample_L = $urandom; i_Sample_R = $urandom; i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    repeat (54) @(negedge clk);
    i_Reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("midreset_cs", 32'(o_SPI_CS), 32'h1);
    check("midreset_sck", 32'(o_SPI_Clock), 32'h0);
    check("midreset_busy", 32'(o_Busy), 32'h0);
    check("midreset_data", 32'(o_SPI_Data), 32'h0);
    i_Reset_n = 1'b1;
    n = rises;
    repeat (5) @(negedge clk);
    check("midreset_no_words", mon_q.size(), 0);
    check("midreset_no_more_sck", rises, n);
    run_frame($urandom, $urandom, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
